// File: rtl/sync_fifo_flagged_pkg.sv
// Shared widths and types for sync_fifo_flagged and its pointer sub-module.
//   ptr_w(depth) : pointer width, at least 1 bit
//   cnt_w(depth) : occupancy width, able to hold 0..depth
//   fifo_err_t   : sticky error flag pair
package sync_fifo_pkg;

  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/sync_fifo_flagged_ptr.sv
// Wrapping pointer for sync_fifo_flagged.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, ptr -> 0
//   inc : advance pointer by one
//   ptr : current pointer, wraps DEPTH-1 -> 0
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  output logic [ptr_w(DEPTH)-1:0]   ptr
);

  localparam int PW = ptr_w(DEPTH);

  // Explicit compare so non-power-of-two depths wrap at DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PW'(DEPTH - 1)) ptr <= '0;
      else                       ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with arbitrary depth, occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// selectable read mode (FWFT show-ahead or registered 1-cycle read).
//   clk, rst                       : clock, synchronous active-high reset
//   wdata, wen, full, almost_full  : write side
//   rdata, ren, rvalid, empty,
//   almost_empty                   : read side
//   count                          : occupancy 0..DEPTH
//   overflow, underflow, err_clr   : sticky error flags and their clear
module sync_fifo_flagged
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter bit FWFT      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     wen,
  output logic                     full,
  output logic                     almost_full,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     ren,
  output logic                     rvalid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if ((DEPTH < 2) || (AEMPTY_TH < 1) || (AEMPTY_TH >= AFULL_TH) || (AFULL_TH > DEPTH)) begin : g_param_err
    $error("sync_fifo_flagged: require DEPTH >= 2 and 1 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             wr_acc;
  logic             rd_acc;
  fifo_err_t        err;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AFULL_TH));
  assign almost_empty = (count <= CW'(AEMPTY_TH));

  assign wr_acc = wen & ~full;
  assign rd_acc = ren & ~empty;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wr_acc && !rd_acc) begin
      count <= count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count <= count - CW'(1);
    end
  end

  // A set event in the same cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= '0;
    end else begin
      if (err_clr)     err           <= '0;
      if (wen && full) err.overflow  <= 1'b1;
      if (ren && empty) err.underflow <= 1'b1;
    end
  end

  assign overflow  = err.overflow;
  assign underflow = err.underflow;

  if (FWFT) begin : g_fwft
    assign rdata  = mem[rptr];
    assign rvalid = ~empty;
  end else begin : g_reg_read
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata  <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= rd_acc;
        if (rd_acc) rdata <= mem[rptr];
      end
    end
  end

endmodule
